// File: rtl/nock_mem_responder_if.sv
// nock_mem_responder_if: execute-block memory request/response bus between an initiator and the responder.
interface nock_mem_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              mem_execute;
    logic [1:0]        mem_func;
    logic [ADDR_W-1:0] address1;
    logic [ADDR_W-1:0] address2;
    logic [DATA_W-1:0] write_data;
    logic              mem_ready;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [ADDR_W-1:0] free_addr;
    logic              busy;
    logic [1:0]        mem_error;

    modport master (
        output mem_execute, mem_func, address1, address2, write_data,
        input  mem_ready, read_data1, read_data2, free_addr, busy, mem_error
    );

    modport slave (
        input  mem_execute, mem_func, address1, address2, write_data,
        output mem_ready, read_data1, read_data2, free_addr, busy, mem_error
    );
endinterface

// File: rtl/nock_mem_responder.sv
// nock_mem_responder: single-port RAM responder for GET/SET/ALLOC with a bump free pointer.
// Optional MEM_WRITE_GUARD_EN rejects SET to NIL or to not-yet-allocated addresses.
module nock_mem_responder #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int FREE_BASE = 16
) (
    input logic                 clk,
    input logic                 rst,
    nock_mem_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, RESP} state_t;

    localparam logic [1:0]        F_NOP   = 2'd0;
    localparam logic [1:0]        F_GET   = 2'd1;
    localparam logic [1:0]        F_SET   = 2'd2;
    localparam logic [1:0]        F_ALLOC = 2'd3;
    localparam logic [ADDR_W-1:0] TOP     = '1;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(FREE_BASE);

    state_t            state, state_nx;
    logic [1:0]        func;
    logic [ADDR_W-1:0] a1, a2, free_q, ram_addr;
    logic [DATA_W-1:0] wdata, ram_q, hold, rd1, rd2;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [1:0]        err, err_out;
    logic              ready, we, oom, reject;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !bus.mem_execute ? IDLE :
                                bus.mem_func == F_GET ? RD_A :
                                bus.mem_func == F_NOP ? RESP : WR;
            RD_A:    state_nx = RD_B;
            RD_B:    state_nx = RESP;
            WR:      state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        oom = func == F_ALLOC && free_q == TOP;
`ifdef MEM_WRITE_GUARD_EN
        reject = func == F_SET && (a1 == '0 || a1 >= free_q);
`else
        reject = 1'b0;
`endif
        // write enable follows state, so an async reset in WR drops the write
        we       = state == WR && !oom && !reject;
        ram_addr = state == RD_B ? a2 : (state == WR && func == F_ALLOC) ? free_q : a1;
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[ram_addr] <= wdata;
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            func    <= F_NOP;
            a1      <= '0;
            a2      <= '0;
            wdata   <= '0;
            hold    <= '0;
            err     <= 2'b00;
            free_q  <= BASE;
            ready   <= 1'b0;
            rd1     <= '0;
            rd2     <= '0;
            err_out <= 2'b00;
        end else begin
            if (state == IDLE && bus.mem_execute) begin
                func  <= bus.mem_func;
                a1    <= bus.address1;
                a2    <= bus.address2;
                wdata <= bus.write_data;
                err   <= 2'b00;
            end
            if (state == RD_B)
                hold <= ram_q;
            if (state == WR) begin
                err <= oom ? 2'b01 : reject ? 2'b10 : 2'b00;
                if (func == F_ALLOC) begin
                    hold <= {{(DATA_W-ADDR_W){1'b0}}, free_q};
                    if (!oom)
                        free_q <= free_q + 1'b1;
                end
            end
            ready <= state == RESP;
            if (state == RESP) begin
                err_out <= err;
                if (func == F_GET || func == F_ALLOC)
                    rd1 <= hold;
                if (func == F_GET)
                    rd2 <= ram_q;
            end
        end
    end

    assign bus.mem_ready  = ready;
    assign bus.read_data1 = rd1;
    assign bus.read_data2 = rd2;
    assign bus.free_addr  = free_q;
    assign bus.mem_error  = err_out;
    assign bus.busy       = state != IDLE || ready;
endmodule
